// File: rtl/polymul_result_unloader.sv
// Collects the multiplier's bit-reversed result stream into a local RAM and
// replays it in natural coefficient order over a valid/ready stream.
module polymul_result_unloader #(
  parameter int DATA_SIZE  = 32,
  parameter int RING_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] din,
  input  logic                 done_all,
  output logic                 fifo_full,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_overflow,
  output logic                 err_short
);

  localparam int N = 1 << RING_DEPTH;

  typedef enum logic {FILL, DRAIN} state_e;
  typedef logic [RING_DEPTH-1:0] idx_t;

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    for (int b = 0; b < RING_DEPTH; b++) r[b] = i[RING_DEPTH-1-b];
    return r;
  endfunction

  state_e state_q, state_d;
  idx_t   wr_idx_q, wr_idx_d;
  idx_t   rd_idx_q, rd_idx_d;
  logic   rd_done_q, rd_done_d;
  logic   m_valid_q, m_valid_d;
  logic   m_last_q, m_last_d;
  logic   fifo_full_q, fifo_full_d;
  logic   busy_q, busy_d;
  logic   err_overflow_q, err_overflow_d;
  logic   err_short_q, err_short_d;
  logic   wr_accept;
  logic   rd_load;

  logic [DATA_SIZE-1:0] mem [N];
  logic [DATA_SIZE-1:0] rd_word_q;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    rd_done_d      = rd_done_q;
    m_valid_d      = m_valid_q;
    m_last_d       = m_last_q;
    err_overflow_d = err_overflow_q;
    err_short_d    = err_short_q;
    wr_accept      = 1'b0;
    rd_load        = 1'b0;

    if (wr_en && fifo_full_q) err_overflow_d = 1'b1;

    case (state_q)
      FILL: begin
        if (wr_en) begin
          wr_accept = 1'b1;
          // A write that completes the frame wins over a coincident done_all.
          if (wr_idx_q == '1) begin
            state_d  = DRAIN;
            wr_idx_d = '0;
          end else if (done_all) begin
            err_short_d = 1'b1;
            wr_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end else if (done_all && wr_idx_q != '0) begin
          err_short_d = 1'b1;
          wr_idx_d    = '0;
        end
      end
      DRAIN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d   = FILL;
          rd_idx_d  = '0;
          rd_done_d = 1'b0;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else if ((!m_valid_q || m_ready) && !rd_done_q) begin
          rd_load   = 1'b1;
          m_valid_d = 1'b1;
          m_last_d  = (rd_idx_q == '1);
          rd_done_d = (rd_idx_q == '1);
          rd_idx_d  = rd_idx_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    fifo_full_d = (state_d == DRAIN);
    busy_d      = (state_d != FILL) || (wr_idx_d != '0);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FILL;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      rd_done_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      fifo_full_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      rd_done_q      <= rd_done_d;
      m_valid_q      <= m_valid_d;
      m_last_q       <= m_last_d;
      fifo_full_q    <= fifo_full_d;
      busy_q         <= busy_d;
      err_overflow_q <= err_overflow_d;
      err_short_q    <= err_short_d;
    end
  end

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[bitrev(wr_idx_q)] <= din;
    if (rd_load)   rd_word_q <= mem[rd_idx_q];
  end

  // Gating with m_valid gives m_data its zero reset value without resetting the RAM port.
  assign m_data       = m_valid_q ? rd_word_q : '0;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign fifo_full    = fifo_full_q;
  assign busy         = busy_q;
  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;

endmodule
